// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers (one step per cycle).
// The restoring divider is compiled in only when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state  | meaning
    // S_IDLE | waiting for start; MTHI/MTLO/no-op complete here
    // S_MUL  | one shift-add step per cycle on magnitudes
    // S_DIV  | one restoring-division step per cycle on magnitudes
    // S_FIX  | sign correction and HI/LO write-back
    localparam int         CW      = $clog2(WIDTH);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg;
    logic               r_done;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_signed;
    logic               w_busy;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
`ifdef MULT_DIV_UNIT_DIV_EN
    logic [WIDTH-1:0]   r_mb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic               r_neg_r;
    logic               r_bzero;
    logic               r_is_div;
    logic               w_is_div;
    logic [WIDTH:0]     w_trial;
`endif

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_mul = (op[2:1] == 2'b00);
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    // Upper half accumulates the multiplicand; multiplier bits shift out of the lower half.
    assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_p[0]}} & r_ma};
`ifdef MULT_DIV_UNIT_DIV_EN
    assign w_is_div = (op[2:1] == 2'b01);
    assign w_trial  = {r_rem, r_q[WIDTH-1]} - {1'b0, r_mb};
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) w_next = S_MUL;
`ifdef MULT_DIV_UNIT_DIV_EN
                else if (w_accept && w_is_div) w_next = S_DIV;
`endif
            end
            S_MUL, S_DIV: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_ma     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            r_mb     <= '0;
            r_a      <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_is_div <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= CW'(WIDTH - 1);
                        r_p   <= {{WIDTH{1'b0}}, w_abs_b};
                        r_ma  <= w_abs_a;
                        r_neg <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_DIV_UNIT_DIV_EN
                        r_mb     <= w_abs_b;
                        r_a      <= a;
                        r_rem    <= '0;
                        r_q      <= w_abs_a;
                        r_neg_r  <= w_signed & a[WIDTH-1];
                        r_bzero  <= (b == '0);
                        r_is_div <= w_is_div;
`endif
                        if (op == OP_MTHI) begin
                            r_hi   <= a;
                            r_done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            r_lo   <= a;
                            r_done <= 1'b1;
                        end else if (op[2:1] == 2'b11) begin
                            r_done <= 1'b1;
                        end
`ifndef MULT_DIV_UNIT_DIV_EN
                        else if (op[2:1] == 2'b01) begin
                            r_done <= 1'b1;
                        end
`endif
                    end
                end
                S_MUL: begin
                    r_p   <= {w_sum, r_p[WIDTH-1:1]};
                    r_cnt <= r_cnt - CW'(1);
                end
`ifdef MULT_DIV_UNIT_DIV_EN
                S_DIV: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                end
`endif
                S_FIX: begin
                    r_done <= 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
                    if (r_is_div) begin
                        // Divide by zero reports the raw dividend, not the magnitude.
                        if (r_bzero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_lo <= r_neg   ? (~r_q + WIDTH'(1))   : r_q;
                            r_hi <= r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
                        end
                    end else
`endif
                    {r_hi, r_lo} <= r_neg ? (~r_p + (2*WIDTH)'(1)) : r_p;
                end
                default: ;
            endcase
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: fixed vectors, reset behaviour and randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference model: updates m_hi/m_lo and returns the expected start-to-done distance in cycles.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                            output int lat);
        logic [63:0] prod;
        int          sa;
        int          sb;
        sa  = $signed(va);
        sb  = $signed(vb);
        lat = 1;
        case (o)
            3'd0: begin
                prod = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = prod;
                lat = W + 2;
            end
            3'd1: begin
                prod = {32'b0, va} * {32'b0, vb};
                {m_hi, m_lo} = prod;
                lat = W + 2;
            end
`ifdef MULT_DIV_UNIT_DIV_EN
            3'd2, 3'd3: begin
                lat = W + 2;
                if (vb == 0) begin
                    m_hi = va;
                    m_lo = '1;
                end else if (o == 3'd2) begin
                    if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
                        m_lo = va;
                        m_hi = '0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end else begin
                    m_lo = va / vb;
                    m_hi = va % vb;
                end
            end
`endif
            3'd4: m_hi = va;
            3'd5: m_lo = va;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the cycle budget).
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit poke, output int lat, output int bcnt, output bit held);
        logic [W-1:0] h0;
        logic [W-1:0] l0;
        h0 = hi;
        l0 = lo;
        lat = -1;
        bcnt = 0;
        held = 1'b1;
        start = 1'b1;
        op = o;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (poke && k == 5) begin
                start = 1'b1;
                op = 3'b100;
                a = ~va;
            end
            if (poke && k == 6) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (hi !== h0 || lo !== l0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 3'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_mult_vector();
        int lat, bcnt, mlat;
        bit held;
        model_op(3'd0, 32'h86E1FB43, 32'h6B72C901, mlat);
        do_op(3'd0, 32'h86E1FB43, 32'h6B72C901, 1'b0, lat, bcnt, held);
        checks++; if (lat != W + 2) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (bcnt != W + 1) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bcnt, W + 1); end
        checks++; if (!held) begin errors++; $display("FAIL mult_hold: hi/lo changed during op, expected held"); end
        checks++; if (hi !== 32'hCD2A258D) begin errors++; $display("FAIL mult_hi: got %h expected CD2A258D", hi); end
        checks++; if (lo !== 32'hD9FF9643) begin errors++; $display("FAIL mult_lo: got %h expected D9FF9643", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_width: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_multu_ignore_start();
        int lat, bcnt, mlat;
        bit held;
        model_op(3'd1, 32'h86E1FB43, 32'h6B72C901, mlat);
        do_op(3'd1, 32'h86E1FB43, 32'h6B72C901, 1'b1, lat, bcnt, held);
        checks++; if (lat != W + 2) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (hi !== 32'h389CEE8E) begin errors++; $display("FAIL multu_hi: got %h expected 389CEE8E", hi); end
        checks++; if (lo !== 32'hD9FF9643) begin errors++; $display("FAIL multu_lo: got %h expected D9FF9643", lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL multu_no_queue: busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_div_vectors();
        int lat, bcnt, mlat;
        bit held;
        logic [W-1:0] h0, l0;
`ifdef MULT_DIV_UNIT_DIV_EN
        model_op(3'd2, 32'h8396A10C, 32'h02A13C92, mlat);
        do_op(3'd2, 32'h8396A10C, 32'h02A13C92, 1'b0, lat, bcnt, held);
        checks++; if (lat != W + 2) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, W + 2); end
        checks++; if (lo !== 32'hFFFFFFD1 || hi !== 32'hFF30BFDA) begin errors++; $display("FAIL div_signed: got hi=%h lo=%h expected hi=FF30BFDA lo=FFFFFFD1", hi, lo); end
        model_op(3'd3, 32'h8396A10C, 32'h02A13C92, mlat);
        do_op(3'd3, 32'h8396A10C, 32'h02A13C92, 1'b0, lat, bcnt, held);
        checks++; if (lo !== 32'h00000032 || hi !== 32'h0018CC88) begin errors++; $display("FAIL divu: got hi=%h lo=%h expected hi=0018CC88 lo=00000032", hi, lo); end
        model_op(3'd3, 32'h12345678, 32'h0, mlat);
        do_op(3'd3, 32'h12345678, 32'h0, 1'b0, lat, bcnt, held);
        checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h12345678 || lat != W + 2) begin errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h lat=%0d expected hi=12345678 lo=FFFFFFFF lat=%0d", hi, lo, lat, W + 2); end
        model_op(3'd2, 32'h80000000, 32'hFFFFFFFF, mlat);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bcnt, held);
        checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL div_overflow: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo); end
`else
        h0 = hi;
        l0 = lo;
        model_op(3'd2, 32'h8396A10C, 32'h02A13C92, mlat);
        do_op(3'd2, 32'h8396A10C, 32'h02A13C92, 1'b0, lat, bcnt, held);
        checks++; if (lat != 1 || bcnt != 0) begin errors++; $display("FAIL div_noop_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bcnt); end
        checks++; if (hi !== h0 || lo !== l0) begin errors++; $display("FAIL div_noop_regs: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, h0, l0); end
        model_op(3'd3, 32'h12345678, 32'h0, mlat);
        do_op(3'd3, 32'h12345678, 32'h0, 1'b0, lat, bcnt, held);
        checks++; if (lat != 1 || hi !== h0 || lo !== l0) begin errors++; $display("FAIL divu_noop: got lat=%0d hi=%h lo=%h expected lat=1 hi=%h lo=%h", lat, hi, lo, h0, l0); end
`endif
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int lat, bcnt, mlat;
        bit held;
        model_op(3'd4, 32'h12345678, 32'h0, mlat);
        do_op(3'd4, 32'h12345678, 32'hDEADBEEF, 1'b0, lat, bcnt, held);
        checks++; if (lat != 1 || bcnt != 0) begin errors++; $display("FAIL mthi_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bcnt); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        // MTLO issued in the MTHI done cycle
        model_op(3'd5, 32'h7B93A612, 32'h0, mlat);
        do_op(3'd5, 32'h7B93A612, 32'h0, 1'b0, lat, bcnt, held);
        checks++; if (lat != 1 || bcnt != 0) begin errors++; $display("FAIL mtlo_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bcnt); end
        checks++; if (hi !== 32'h12345678 || lo !== 32'h7B93A612) begin errors++; $display("FAIL mtlo_regs: got hi=%h lo=%h expected hi=12345678 lo=7B93A612", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, mlat;
        bit held;
        logic [2:0] seq [4];
        logic [W-1:0] va, vb;
        seq[0] = 3'd1; seq[1] = 3'd0; seq[2] = 3'd6; seq[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            va = $urandom;
            vb = $urandom;
            model_op(seq[i], va, vb, mlat);
            do_op(seq[i], va, vb, 1'b0, lat, bcnt, held);
            checks++; if (lat != mlat || hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_%0d: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h", i, lat, hi, lo, mlat, m_hi, m_lo); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bcnt, mlat, sel;
        bit held;
        logic [2:0] o;
        logic [W-1:0] va, vb;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            va = $urandom;
            vb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) vb = '0;
            else if (sel == 1) begin va = 32'h80000000; vb = 32'hFFFFFFFF; end
            else if (sel == 2) vb = 32'($urandom_range(1, 300));
            model_op(o, va, vb, mlat);
            do_op(o, va, vb, 1'b0, lat, bcnt, held);
            checks++; if (lat != mlat || bcnt != ((mlat > 1) ? mlat - 1 : 0) || !held) begin errors++; $display("FAIL rand_%0d_timing op=%0d: got lat=%0d busy=%0d held=%0d expected lat=%0d", i, o, lat, bcnt, held, mlat); end
            checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rand_%0d_value op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h", i, o, va, vb, hi, lo, m_hi, m_lo); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        start = 1'b1;
        op = 3'd0;
        a = 32'h86E1FB43;
        b = 32'h6B72C901;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL abort_regs: got hi=%h lo=%h expected 0 0", hi, lo); end
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin errors++; $display("FAIL abort_done: done pulse seen, expected none"); end
        // reset and MTHI on the same edge: reset wins
        reset = 1'b1;
        start = 1'b1;
        op = 3'd4;
        a = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if (hi !== '0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_priority: got hi=%h done=%b busy=%b expected 0 0 0", hi, done, busy); end
    endtask

    initial begin
        test_reset();
        test_mult_vector();
        test_multu_ignore_start();
        test_div_vectors();
        test_mthi_mtlo();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
